ysyx_25030093_lsu: RTL and testbench

- Load/store stage directly upstream of the write-back stage.
- Accepts one instruction at a time from the execute stage and issues at most one request on a simple req/gnt/rvalid data-memory port.
- Aligns loaded data and sign- or zero-extends it; for stores, generates byte-lane data and mask.
- Hands write-back the load result (`lsu_data`), the execute result (`rd_data`), and the select flag (`rd_or_lsu_sel`) under a valid/ready handshake.

---
 rtl/ysyx_25030093_lsu_pkg.sv | 33 +++
 rtl/ysyx_25030093_lsu_if.sv | 23 ++
 rtl/ysyx_25030093_lsu_align.sv | 52 +++++
 rtl/ysyx_25030093_lsu.sv | 176 +++++++++++++++++
 tb/tb_ysyx_25030093_lsu.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_25030093_lsu_pkg.sv
// Shared types and constants for the ysyx_25030093 load/store unit.
package ysyx_25030093_lsu_pkg;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_e;

   typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} lsu_size_e;

   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;

   localparam int MEM_TIMEOUT_DEF = 255;

   // Any funct3 encoding that is not a byte or halfword access behaves as a word.
   function automatic lsu_size_e f3_size(input logic [2:0] f3);
      case (f3)
         LB, LBU: return SZ_B;
         LH, LHU: return SZ_H;
         default: return SZ_W;
      endcase
   endfunction

   function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
      case (f3_size(f3))
         SZ_H:    return off[0];
         SZ_W:    return off != 2'b00;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/ysyx_25030093_lsu_if.sv
// Data-memory port of the LSU: req/gnt request phase, rvalid response phase.
interface ysyx_25030093_lsu_if #(
   parameter int XLEN = 32
);
   logic            mem_req;
   logic            mem_we;
   logic [XLEN-1:0] mem_addr;
   logic [XLEN-1:0] mem_wdata;
   logic [3:0]      mem_wmask;
   logic            mem_gnt;
   logic            mem_rvalid;
   logic [XLEN-1:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
      input  mem_gnt, mem_rvalid, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
      output mem_gnt, mem_rvalid, mem_rdata
   );
endinterface

// File: rtl/ysyx_25030093_lsu_align.sv
// Byte-lane steering: store data/mask generation and load extraction/extension.
module ysyx_25030093_lsu_align
   import ysyx_25030093_lsu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]      i_st_funct3,
   input  logic [1:0]      i_st_off,
   input  logic [XLEN-1:0] i_store_data,
   output logic [XLEN-1:0] o_wdata,
   output logic [3:0]      o_wmask,
   input  logic [2:0]      i_ld_funct3,
   input  logic [1:0]      i_ld_off,
   input  logic [XLEN-1:0] i_rdata,
   output logic [XLEN-1:0] o_ld_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic        w_signed;

   assign w_byte   = i_rdata[{i_ld_off, 3'b000} +: 8];
   assign w_half   = i_rdata[{i_ld_off[1], 4'b0000} +: 16];
   assign w_signed = ~i_ld_funct3[2];

   // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      o_wdata = i_store_data;
      o_wmask = 4'b1111;
      case (f3_size(i_st_funct3))
         SZ_B: begin
            o_wdata = {4{i_store_data[7:0]}};
            o_wmask = 4'b0001 << i_st_off;
         end
         SZ_H: begin
            o_wdata = {2{i_store_data[15:0]}};
            o_wmask = 4'b0011 << {i_st_off[1], 1'b0};
         end
         default: ;
      endcase
   end

   always_comb begin
      o_ld_data = i_rdata;
      case (f3_size(i_ld_funct3))
         SZ_B:    o_ld_data = {{(XLEN-8){w_signed & w_byte[7]}}, w_byte};
         SZ_H:    o_ld_data = {{(XLEN-16){w_signed & w_half[15]}}, w_half};
         default: ;
      endcase
   end

endmodule

// File: rtl/ysyx_25030093_lsu.sv
// Load/store unit: one instruction in flight, req/gnt/rvalid memory port, timeout to bus_err.
// Optional LSU_MISALIGN_CHECK_EN adds a misalign output and skips misaligned accesses.
module ysyx_25030093_lsu
   import ysyx_25030093_lsu_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [XLEN-1:0]       exu_result,
   input  logic [XLEN-1:0]       store_data,
   input  logic                  is_load,
   input  logic                  is_store,
   input  logic [2:0]            funct3,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [XLEN-1:0]       rd_data,
   output logic [XLEN-1:0]       lsu_data,
   output logic                  rd_or_lsu_sel,
   ysyx_25030093_lsu_if.master   mem,
`ifdef LSU_MISALIGN_CHECK_EN
   output logic                  misalign,
`endif
   output logic                  bus_err
);

   localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

   lsu_state_e       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_in_ready, r_out_valid, r_sel, r_bus_err, r_is_load;
   logic [2:0]       r_funct3;
   logic [1:0]       r_off;
   logic [XLEN-1:0]  r_rd_data, r_lsu_data;
   logic             r_mem_req, r_mem_we;
   logic [XLEN-1:0]  r_mem_addr, r_mem_wdata;
   logic [3:0]       r_mem_wmask;
`ifdef LSU_MISALIGN_CHECK_EN
   logic             r_misalign;
`endif

   logic [XLEN-1:0]  w_wdata, w_ld_data;
   logic [3:0]       w_wmask;
   logic             w_load, w_mem_op, w_rsp, w_stall, w_tmo;

   ysyx_25030093_lsu_align #(.XLEN(XLEN)) u_align (
      .i_st_funct3  (funct3),
      .i_st_off     (exu_result[1:0]),
      .i_store_data (store_data),
      .o_wdata      (w_wdata),
      .o_wmask      (w_wmask),
      .i_ld_funct3  (r_funct3),
      .i_ld_off     (r_off),
      .i_rdata      (mem.mem_rdata),
      .o_ld_data    (w_ld_data)
   );

   // A load+store encoding is treated as a store.
   assign w_load   = is_load & ~is_store;
   assign w_mem_op = is_load | is_store;
   assign w_rsp    = (r_state == REQ  && mem.mem_gnt && mem.mem_rvalid)
                  || (r_state == WAIT && mem.mem_rvalid);
   assign w_stall  = (r_state == REQ  && !mem.mem_gnt)
                  || (r_state == WAIT && !mem.mem_rvalid);
   assign w_tmo    = w_stall && (MEM_TIMEOUT != 0) && (r_cnt == CNT_LAST);

   // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_sel       <= 1'b0;
         r_bus_err   <= 1'b0;
         r_is_load   <= 1'b0;
         r_funct3    <= '0;
         r_off       <= '0;
         r_rd_data   <= '0;
         r_lsu_data  <= '0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_mem_wmask <= '0;
`ifdef LSU_MISALIGN_CHECK_EN
         r_misalign  <= 1'b0;
`endif
      end else begin
         r_bus_err <= 1'b0;
         case (r_state)
            IDLE: if (in_valid) begin
               r_in_ready <= 1'b0;
               r_rd_data  <= exu_result;
               r_funct3   <= funct3;
               r_off      <= exu_result[1:0];
               r_is_load  <= w_load;
               r_cnt      <= '0;
               if (!w_mem_op) begin
                  r_sel       <= 1'b0;
                  r_out_valid <= 1'b1;
                  r_state     <= DONE;
               end
`ifdef LSU_MISALIGN_CHECK_EN
               else if (is_misaligned(funct3, exu_result[1:0])) begin
                  r_misalign  <= 1'b1;
                  r_lsu_data  <= '0;
                  r_sel       <= w_load;
                  r_out_valid <= 1'b1;
                  r_state     <= DONE;
               end
`endif
               else begin
                  r_mem_req   <= 1'b1;
                  r_mem_we    <= is_store;
                  r_mem_addr  <= {exu_result[XLEN-1:2], 2'b00};
                  r_mem_wdata <= is_store ? w_wdata : '0;
                  r_mem_wmask <= is_store ? w_wmask : 4'b0000;
                  r_state     <= REQ;
               end
            end
            REQ, WAIT: begin
               if (w_rsp) begin
                  r_mem_req   <= 1'b0;
                  r_sel       <= r_is_load;
                  r_out_valid <= 1'b1;
                  r_state     <= DONE;
                  if (r_is_load) r_lsu_data <= w_ld_data;
               end else if (w_tmo) begin
                  r_mem_req   <= 1'b0;
                  r_bus_err   <= 1'b1;
                  r_lsu_data  <= '0;
                  r_sel       <= r_is_load;
                  r_out_valid <= 1'b1;
                  r_state     <= DONE;
               end else if (r_state == REQ && mem.mem_gnt) begin
                  r_mem_req <= 1'b0;
                  r_cnt     <= '0;
                  r_state   <= WAIT;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            DONE: if (out_ready) begin
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
               r_state     <= IDLE;
`ifdef LSU_MISALIGN_CHECK_EN
               r_misalign  <= 1'b0;
`endif
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign in_ready      = r_in_ready;
   assign out_valid     = r_out_valid;
   assign rd_data       = r_rd_data;
   assign lsu_data      = r_lsu_data;
   assign rd_or_lsu_sel = r_sel;
   assign bus_err       = r_bus_err;
   assign mem.mem_req   = r_mem_req;
   assign mem.mem_we    = r_mem_we;
   assign mem.mem_addr  = r_mem_addr;
   assign mem.mem_wdata = r_mem_wdata;
   assign mem.mem_wmask = r_mem_wmask;
`ifdef LSU_MISALIGN_CHECK_EN
   assign misalign      = r_misalign;
`endif

endmodule

// File: tb/tb_ysyx_25030093_lsu.sv
// Directed self-checking bench for ysyx_25030093_lsu with MEM_TIMEOUT = 8.
module tb_ysyx_25030093_lsu;
   import ysyx_25030093_lsu_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        in_valid, in_ready;
   logic [31:0] exu_result, store_data;
   logic        is_load, is_store;
   logic [2:0]  funct3;
   logic        out_valid, out_ready;
   logic [31:0] rd_data, lsu_data;
   logic        rd_or_lsu_sel, bus_err;
`ifdef LSU_MISALIGN_CHECK_EN
   logic        misalign;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   ysyx_25030093_lsu_if #(.XLEN(32)) mem_bus ();

   ysyx_25030093_lsu #(.XLEN(32), .MEM_TIMEOUT(8)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .exu_result    (exu_result),
      .store_data    (store_data),
      .is_load       (is_load),
      .is_store      (is_store),
      .funct3        (funct3),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .rd_data       (rd_data),
      .lsu_data      (lsu_data),
      .rd_or_lsu_sel (rd_or_lsu_sel),
      .mem           (mem_bus.master),
`ifdef LSU_MISALIGN_CHECK_EN
      .misalign      (misalign),
`endif
      .bus_err       (bus_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [31:0] addr, input logic [31:0] sdata,
                        input logic ld, input logic st, input logic [2:0] f3);
      in_valid   = 1'b1;
      exu_result = addr;
      store_data = sdata;
      is_load    = ld;
      is_store   = st;
      funct3     = f3;
      tick();
      in_valid = 1'b0;
      is_load  = 1'b0;
      is_store = 1'b0;
   endtask

   task automatic retire();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic run_alu(input string tag, input logic [31:0] val);
      issue(val, 32'h0, 1'b0, 1'b0, LW);
      check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
      check({tag, ".rd_data"}, rd_data, val);
      check({tag, ".sel"}, 32'(rd_or_lsu_sel), 32'd0);
      check({tag, ".mem_req"}, 32'(mem_bus.mem_req), 32'd0);
      retire();
      check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
      check({tag, ".mem_req_after"}, 32'(mem_bus.mem_req), 32'd0);
   endtask

   // Zero-wait load: gnt in the first REQ cycle, rvalid in the following cycle.
   task automatic run_load(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                           input logic [31:0] rdata, input logic [31:0] exp_addr,
                           input logic [31:0] exp_data);
      issue(addr, 32'h0, 1'b1, 1'b0, f3);
      check({tag, ".mem_req"}, 32'(mem_bus.mem_req), 32'd1);
      check({tag, ".mem_addr"}, mem_bus.mem_addr, exp_addr);
      check({tag, ".mem_we"}, 32'(mem_bus.mem_we), 32'd0);
      mem_bus.mem_gnt = 1'b1;
      tick();
      mem_bus.mem_gnt = 1'b0;
      check({tag, ".req_drop"}, 32'(mem_bus.mem_req), 32'd0);
      check({tag, ".not_yet"}, 32'(out_valid), 32'd0);
      mem_bus.mem_rvalid = 1'b1;
      mem_bus.mem_rdata  = rdata;
      tick();
      mem_bus.mem_rvalid = 1'b0;
      mem_bus.mem_rdata  = 32'h0;
      check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
      check({tag, ".lsu_data"}, lsu_data, exp_data);
      check({tag, ".sel"}, 32'(rd_or_lsu_sel), 32'd1);
      check({tag, ".rd_data"}, rd_data, addr);
      retire();
   endtask

   initial begin
      int n_cyc;
      int n_err;

      rst_n      = 1'b0;
      in_valid   = 1'b0;
      exu_result = 32'h0;
      store_data = 32'h0;
      is_load    = 1'b0;
      is_store   = 1'b0;
      funct3     = 3'b000;
      out_ready  = 1'b0;
      mem_bus.mem_gnt    = 1'b0;
      mem_bus.mem_rvalid = 1'b0;
      mem_bus.mem_rdata  = 32'h0;

      tick();
      check("rst.in_ready", 32'(in_ready), 32'd1);
      check("rst.out_valid", 32'(out_valid), 32'd0);
      check("rst.mem_req", 32'(mem_bus.mem_req), 32'd0);
      check("rst.mem_we", 32'(mem_bus.mem_we), 32'd0);
      check("rst.bus_err", 32'(bus_err), 32'd0);
      check("rst.sel", 32'(rd_or_lsu_sel), 32'd0);
      check("rst.rd_data", rd_data, 32'h0);
      check("rst.lsu_data", lsu_data, 32'h0);
      check("rst.mem_addr", mem_bus.mem_addr, 32'h0);
      check("rst.mem_wdata", mem_bus.mem_wdata, 32'h0);
      check("rst.mem_wmask", 32'(mem_bus.mem_wmask), 32'h0);
      rst_n = 1'b1;
      tick();

      run_alu("alu1", 32'h0000_1234);

      run_load("lb", 32'h0000_1003, LB, 32'h80FF_0000, 32'h0000_1000, 32'hFFFF_FF80);
      run_load("lh", 32'h0000_0002, LH, 32'h8001_1234, 32'h0000_0000, 32'hFFFF_8001);
      run_load("lbu", 32'h0000_0005, LBU, 32'h0000_A500, 32'h0000_0004, 32'h0000_00A5);
      run_load("lb_pos", 32'h0000_0010, LB, 32'hFFFF_FF7F, 32'h0000_0010, 32'h0000_007F);
      run_load("lw", 32'h0000_0008, LW, 32'hCAFE_F00D, 32'h0000_0008, 32'hCAFE_F00D);
      run_load("f3_111", 32'h0000_000E, 3'b111, 32'h1234_5678, 32'h0000_000C, 32'h1234_5678);

      run_alu("alu2", 32'h5555_AAAA);

      // SH with a grant delayed three cycles: request fields must hold steady.
      issue(32'h0000_2002, 32'hAAAA_BEEF, 1'b0, 1'b1, LH);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("sh.req%0d", i), 32'(mem_bus.mem_req), 32'd1);
         check($sformatf("sh.addr%0d", i), mem_bus.mem_addr, 32'h0000_2000);
         check($sformatf("sh.wdata%0d", i), mem_bus.mem_wdata, 32'hBEEF_BEEF);
         check($sformatf("sh.wmask%0d", i), 32'(mem_bus.mem_wmask), 32'hC);
         check($sformatf("sh.we%0d", i), 32'(mem_bus.mem_we), 32'd1);
         if (i == 3) mem_bus.mem_gnt = 1'b1;
         tick();
      end
      mem_bus.mem_gnt = 1'b0;
      check("sh.req_drop", 32'(mem_bus.mem_req), 32'd0);
      mem_bus.mem_rvalid = 1'b1;
      tick();
      mem_bus.mem_rvalid = 1'b0;
      check("sh.out_valid", 32'(out_valid), 32'd1);
      check("sh.sel", 32'(rd_or_lsu_sel), 32'd0);
      retire();

      // SB with gnt and rvalid together: straight to DONE.
      issue(32'h0000_2001, 32'h1234_5678, 1'b0, 1'b1, LB);
      check("sb.wdata", mem_bus.mem_wdata, 32'h7878_7878);
      check("sb.wmask", 32'(mem_bus.mem_wmask), 32'h2);
      check("sb.addr", mem_bus.mem_addr, 32'h0000_2000);
      mem_bus.mem_gnt    = 1'b1;
      mem_bus.mem_rvalid = 1'b1;
      tick();
      mem_bus.mem_gnt    = 1'b0;
      mem_bus.mem_rvalid = 1'b0;
      check("sb.out_valid", 32'(out_valid), 32'd1);
      check("sb.req_drop", 32'(mem_bus.mem_req), 32'd0);
      check("sb.sel", 32'(rd_or_lsu_sel), 32'd0);
      retire();

      // Load and store both set: behaves as a word store.
      issue(32'h0000_3000, 32'h1122_3344, 1'b1, 1'b1, LW);
      check("ldst.we", 32'(mem_bus.mem_we), 32'd1);
      check("ldst.wdata", mem_bus.mem_wdata, 32'h1122_3344);
      check("ldst.wmask", 32'(mem_bus.mem_wmask), 32'hF);
      mem_bus.mem_gnt    = 1'b1;
      mem_bus.mem_rvalid = 1'b1;
      tick();
      mem_bus.mem_gnt    = 1'b0;
      mem_bus.mem_rvalid = 1'b0;
      check("ldst.sel", 32'(rd_or_lsu_sel), 32'd0);
      retire();

      // LHU with write-back stalled four cycles in DONE.
      issue(32'h0000_0000, 32'h0, 1'b1, 1'b0, LHU);
      mem_bus.mem_gnt = 1'b1;
      tick();
      mem_bus.mem_gnt    = 1'b0;
      mem_bus.mem_rvalid = 1'b1;
      mem_bus.mem_rdata  = 32'h0000_8001;
      tick();
      mem_bus.mem_rvalid = 1'b0;
      mem_bus.mem_rdata  = 32'hFFFF_FFFF;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("lhu.data%0d", i), lsu_data, 32'h0000_8001);
         check($sformatf("lhu.valid%0d", i), 32'(out_valid), 32'd1);
         check($sformatf("lhu.in_ready%0d", i), 32'(in_ready), 32'd0);
         tick();
      end
      check("lhu.in_ready_hs", 32'(in_ready), 32'd0);
      out_ready  = 1'b1;
      in_valid   = 1'b1;
      exu_result = 32'h0000_0077;
      tick();
      out_ready = 1'b0;
      in_valid  = 1'b0;
      check("lhu.in_ready_after", 32'(in_ready), 32'd1);
      check("lhu.no_reaccept", 32'(out_valid), 32'd0);
      mem_bus.mem_rdata = 32'h0;

      // Load that never gets rvalid: timeout after 8 WAIT cycles.
      issue(32'h0000_0040, 32'h0, 1'b1, 1'b0, LW);
      mem_bus.mem_gnt = 1'b1;
      tick();
      mem_bus.mem_gnt = 1'b0;
      n_cyc = 0;
      n_err = 0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (bus_err) n_err++;
         if (out_valid) begin
            n_cyc = i;
            break;
         end
      end
      check("to.cycles", 32'(n_cyc), 32'd8);
      check("to.lsu_data", lsu_data, 32'h0);
      mem_bus.mem_rvalid = 1'b1;
      mem_bus.mem_rdata  = 32'hDEAD_BEEF;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (bus_err) n_err++;
      end
      mem_bus.mem_rvalid = 1'b0;
      mem_bus.mem_rdata  = 32'h0;
      check("to.bus_err_pulses", 32'(n_err), 32'd1);
      check("to.late_rvalid", lsu_data, 32'h0);
      check("to.out_valid", 32'(out_valid), 32'd1);
      retire();

      // Rerun and assert reset while waiting for the response.
      issue(32'h0000_0044, 32'h0, 1'b1, 1'b0, LW);
      mem_bus.mem_gnt = 1'b1;
      tick();
      mem_bus.mem_gnt = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      check("mid_rst.in_ready", 32'(in_ready), 32'd1);
      check("mid_rst.out_valid", 32'(out_valid), 32'd0);
      check("mid_rst.mem_req", 32'(mem_bus.mem_req), 32'd0);
      check("mid_rst.rd_data", rd_data, 32'h0);
      check("mid_rst.mem_addr", mem_bus.mem_addr, 32'h0);
      check("mid_rst.sel", 32'(rd_or_lsu_sel), 32'd0);
      #1;
      rst_n = 1'b1;
      tick();
      run_alu("alu3", 32'h0000_ABCD);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
